// File: rtl/dma_read_requester.sv
// Splits one DW-aligned read descriptor into memory-read requests bounded by
// max read request size and 4 KB pages, throttled by an outstanding-request limit.
module dma_read_requester #(
  parameter int P_MRRS_DW         = 128,
  parameter int P_MAX_OUTSTANDING = 8,
  parameter int P_CNT_WIDTH       = 6
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            desc_addr,
  input  logic [15:0]            desc_len_dw,
  input  logic                   desc_valid,
  output logic                   desc_ready,
  output logic                   desc_done,
  output logic [31:0]            dma_read_addr,
  output logic [9:0]             dma_read_len,
  output logic                   dma_read_valid,
  input  logic                   dma_read_done,
  input  logic [7:0]             current_tag,
  output logic                   issue_pulse,
  output logic [7:0]             issue_tag,
  output logic [9:0]             issue_len,
  input  logic                   cpl_req_done,
  output logic [P_CNT_WIDTH-1:0] outstanding,
  output logic                   busy
);

  // state      | meaning
  // S_IDLE     | waiting for a descriptor, desc_ready high
  // S_CALC     | size next chunk, wait for a free credit
  // S_REQ      | request offered, waiting for dma_read_done
  // S_WAIT_CPL | all issued, waiting for outstanding to drain
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_REQ, S_WAIT_CPL} state_t;

  localparam logic [15:0]            MRRS    = 16'(P_MRRS_DW);
  localparam logic [P_CNT_WIDTH-1:0] MAX_OUT = P_CNT_WIDTH'(P_MAX_OUTSTANDING);
  localparam logic [P_CNT_WIDTH-1:0] ONE     = P_CNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [31:0]            cur_addr_q, cur_addr_d;
  logic [15:0]            rem_q, rem_d;
  logic [31:0]            dma_read_addr_q, dma_read_addr_d;
  logic [9:0]             dma_read_len_q, dma_read_len_d;
  logic                   dma_read_valid_q, dma_read_valid_d;
  logic                   issue_pulse_q, issue_pulse_d;
  logic [7:0]             issue_tag_q, issue_tag_d;
  logic [9:0]             issue_len_q, issue_len_d;
  logic                   desc_done_q, desc_done_d;
  logic                   desc_ready_q, desc_ready_d;
  logic [P_CNT_WIDTH-1:0] outstanding_q, outstanding_d;

  logic [10:0] dw_to_4k;
  logic [15:0] chunk;
  logic [15:0] rem_next;
  logic        accept;
  logic        cpl_dec;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^desc_addr[1:0];

  // cur_addr and rem are stable from CALC through REQ, so chunk is the same
  // value in both states and can drive the post-acceptance update directly.
  always_comb begin
    dw_to_4k = 11'd1024 - {1'b0, cur_addr_q[11:2]};
    chunk    = rem_q;
    if (chunk > MRRS) chunk = MRRS;
    if (chunk > {5'b0, dw_to_4k}) chunk = {5'b0, dw_to_4k};
    rem_next = rem_q - chunk;
  end

  assign accept  = dma_read_valid_q && dma_read_done;
  assign cpl_dec = cpl_req_done && (outstanding_q != '0);

  always_comb begin
    state_d          = state_q;
    cur_addr_d       = cur_addr_q;
    rem_d            = rem_q;
    dma_read_addr_d  = dma_read_addr_q;
    dma_read_len_d   = dma_read_len_q;
    dma_read_valid_d = dma_read_valid_q;
    issue_pulse_d    = 1'b0;
    issue_tag_d      = issue_tag_q;
    issue_len_d      = issue_len_q;
    desc_done_d      = 1'b0;

    case ({accept, cpl_dec})
      2'b10:   outstanding_d = outstanding_q + ONE;
      2'b01:   outstanding_d = outstanding_q - ONE;
      default: outstanding_d = outstanding_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (desc_valid && desc_ready_q) begin
          cur_addr_d = {desc_addr[31:2], 2'b00};
          rem_d      = desc_len_dw;
          state_d    = (desc_len_dw == 16'd0) ? S_WAIT_CPL : S_CALC;
        end
      end
      S_CALC: begin
        if (outstanding_q < MAX_OUT) begin
          dma_read_addr_d  = cur_addr_q;
          dma_read_len_d   = chunk[9:0];
          dma_read_valid_d = 1'b1;
          state_d          = S_REQ;
        end
      end
      S_REQ: begin
        if (accept) begin
          dma_read_valid_d = 1'b0;
          issue_pulse_d    = 1'b1;
          issue_tag_d      = current_tag;
          issue_len_d      = dma_read_len_q;
          cur_addr_d       = cur_addr_q + {14'b0, chunk, 2'b00};
          rem_d            = rem_next;
          state_d          = (rem_next != 16'd0) ? S_CALC : S_WAIT_CPL;
        end
      end
      S_WAIT_CPL: begin
        if (outstanding_q == '0) begin
          desc_done_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready is held off during the done pulse so it rises one cycle later.
    desc_ready_d = (state_d == S_IDLE) && !desc_done_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q          <= S_IDLE;
      cur_addr_q       <= '0;
      rem_q            <= '0;
      dma_read_addr_q  <= '0;
      dma_read_len_q   <= '0;
      dma_read_valid_q <= 1'b0;
      issue_pulse_q    <= 1'b0;
      issue_tag_q      <= '0;
      issue_len_q      <= '0;
      desc_done_q      <= 1'b0;
      desc_ready_q     <= 1'b1;
      outstanding_q    <= '0;
    end else begin
      state_q          <= state_d;
      cur_addr_q       <= cur_addr_d;
      rem_q            <= rem_d;
      dma_read_addr_q  <= dma_read_addr_d;
      dma_read_len_q   <= dma_read_len_d;
      dma_read_valid_q <= dma_read_valid_d;
      issue_pulse_q    <= issue_pulse_d;
      issue_tag_q      <= issue_tag_d;
      issue_len_q      <= issue_len_d;
      desc_done_q      <= desc_done_d;
      desc_ready_q     <= desc_ready_d;
      outstanding_q    <= outstanding_d;
    end
  end

  assign desc_ready     = desc_ready_q;
  assign desc_done      = desc_done_q;
  assign dma_read_addr  = dma_read_addr_q;
  assign dma_read_len   = dma_read_len_q;
  assign dma_read_valid = dma_read_valid_q;
  assign issue_pulse    = issue_pulse_q;
  assign issue_tag      = issue_tag_q;
  assign issue_len      = issue_len_q;
  assign outstanding    = outstanding_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_dma_read_requester.sv
// Directed bench for dma_read_requester: descriptor table plus hand-written
// sequences for zero length, credit throttling and reset mid-request.
module tb_dma_read_requester;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] desc_addr;
  logic [15:0] desc_len_dw;
  logic        desc_valid;
  logic        desc_ready;
  logic        desc_done;
  logic [31:0] dma_read_addr;
  logic [9:0]  dma_read_len;
  logic        dma_read_valid;
  logic        dma_read_done;
  logic [7:0]  current_tag;
  logic        issue_pulse;
  logic [7:0]  issue_tag;
  logic [9:0]  issue_len;
  logic        cpl_req_done;
  logic [5:0]  outstanding;
  logic        busy;

  always #5 i_clk = ~i_clk;

  dma_read_requester #(
    .P_MRRS_DW(128), .P_MAX_OUTSTANDING(4), .P_CNT_WIDTH(6)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .desc_addr(desc_addr), .desc_len_dw(desc_len_dw), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .desc_done(desc_done),
    .dma_read_addr(dma_read_addr), .dma_read_len(dma_read_len),
    .dma_read_valid(dma_read_valid), .dma_read_done(dma_read_done),
    .current_tag(current_tag), .issue_pulse(issue_pulse), .issue_tag(issue_tag),
    .issue_len(issue_len), .cpl_req_done(cpl_req_done),
    .outstanding(outstanding), .busy(busy)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] len;
    int          nreq;
    int          hold;
    int          mode;
    logic [31:0] ea[3];
    logic [9:0]  el[3];
  } vec_t;

  vec_t        vecs[6];
  int          n_chk = 0;
  int          n_fail = 0;
  int          out_m = 0;
  logic [7:0]  tag_ctr;
  logic [31:0] exp_addr_q[$];
  logic [9:0]  exp_len_q[$];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic set_vec(input int i, input logic [31:0] a, input logic [15:0] l,
                         input int n, input int h, input int m,
                         input logic [31:0] a0, input logic [9:0] l0,
                         input logic [31:0] a1, input logic [9:0] l1,
                         input logic [31:0] a2, input logic [9:0] l2);
    vecs[i].addr = a;  vecs[i].len = l;  vecs[i].nreq = n;
    vecs[i].hold = h;  vecs[i].mode = m;
    vecs[i].ea[0] = a0; vecs[i].ea[1] = a1; vecs[i].ea[2] = a2;
    vecs[i].el[0] = l0; vecs[i].el[1] = l1; vecs[i].el[2] = l2;
  endtask

  task automatic start_desc(input logic [31:0] a, input logic [15:0] l);
    chk("desc_ready_idle", 32'(desc_ready), 1);
    desc_addr   = a;
    desc_len_dw = l;
    desc_valid  = 1'b1;
    tick();
    desc_valid  = 1'b0;
    desc_addr   = 32'hDEAD_BEEF;
    desc_len_dw = 16'hFFFF;
    chk("desc_ready_taken", 32'(desc_ready), 0);
    chk("busy_taken", 32'(busy), 1);
  endtask

  // TX-engine model: answers each offered request with dma_read_done held
  // for 'hold' cycles. mode 1 also pulses cpl_req_done on acceptance edges.
  task automatic issue_phase(input int n, input int hold, input int mode);
    int          k;
    int          hold_left;
    int          cyc;
    logic        pend;
    logic [7:0]  pend_tag;
    logic [9:0]  pend_len;
    logic [31:0] ea;
    logic [9:0]  el;
    k = 0; hold_left = 0; cyc = 0; pend = 1'b0; pend_tag = '0; pend_len = '0;
    while ((k < n || pend) && cyc < 400) begin
      if (pend) begin
        chk("issue_pulse", 32'(issue_pulse), 1);
        chk("issue_tag", 32'(issue_tag), 32'(pend_tag));
        chk("issue_len", 32'(issue_len), 32'(pend_len));
        chk("outstanding_issue", 32'(outstanding), 32'(out_m));
        chk("valid_dropped", 32'(dma_read_valid), 0);
      end else begin
        chk("no_issue_pulse", 32'(issue_pulse), 0);
      end
      pend = 1'b0;
      cpl_req_done = 1'b0;
      if (hold_left > 0) begin
        dma_read_done = 1'b1;
        hold_left--;
      end else if (dma_read_valid) begin
        dma_read_done = 1'b1;
        hold_left = hold - 1;
      end else begin
        dma_read_done = 1'b0;
      end
      current_tag = tag_ctr;
      if (dma_read_valid && dma_read_done && k < n) begin
        ea = exp_addr_q.pop_front();
        el = exp_len_q.pop_front();
        chk("req_addr", dma_read_addr, ea);
        chk("req_len", 32'(dma_read_len), 32'(el));
        pend = 1'b1;
        pend_tag = tag_ctr;
        pend_len = el;
        tag_ctr = tag_ctr + 8'd3;
        out_m++;
        if (mode == 1 && out_m > 1) begin
          cpl_req_done = 1'b1;
          out_m--;
        end
        k++;
      end
      tick();
      cyc++;
    end
    if (k < n || pend) fail_now("issue_phase");
    dma_read_done = 1'b0;
    cpl_req_done  = 1'b0;
  endtask

  task automatic finish_desc();
    repeat (2) begin
      chk("no_extra_request", 32'(dma_read_valid), 0);
      tick();
    end
    chk("outstanding_pre_cpl", 32'(outstanding), 32'(out_m));
    while (out_m > 0) begin
      chk("no_early_done", 32'(desc_done), 0);
      cpl_req_done = 1'b1;
      out_m--;
      tick();
    end
    cpl_req_done = 1'b0;
    chk("outstanding_drained", 32'(outstanding), 0);
    chk("done_not_yet", 32'(desc_done), 0);
    tick();
    chk("desc_done_pulse", 32'(desc_done), 1);
    chk("ready_low_with_done", 32'(desc_ready), 0);
    tick();
    chk("desc_done_single", 32'(desc_done), 0);
    chk("ready_after_done", 32'(desc_ready), 1);
    chk("busy_after_done", 32'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    i_rst = 1'b1; desc_addr = '0; desc_len_dw = '0; desc_valid = 1'b0;
    dma_read_done = 1'b0; current_tag = '0; cpl_req_done = 1'b0;
    tag_ctr = 8'h10;

    set_vec(0, 32'h0000_1000, 16'd300, 3, 1, 1,
            32'h1000, 10'd128, 32'h1200, 10'd128, 32'h1400, 10'd44);
    set_vec(1, 32'h0000_0FF0, 16'd16, 2, 5, 0,
            32'h0FF0, 10'd4, 32'h1000, 10'd12, 32'h0, 10'd0);
    set_vec(2, 32'h0000_0FF3, 16'd5, 2, 1, 0,
            32'h0FF0, 10'd4, 32'h1000, 10'd1, 32'h0, 10'd0);
    set_vec(3, 32'h0000_2000, 16'd128, 1, 2, 0,
            32'h2000, 10'd128, 32'h0, 10'd0, 32'h0, 10'd0);
    set_vec(4, 32'h0000_3E04, 16'd200, 2, 3, 1,
            32'h3E04, 10'd127, 32'h4000, 10'd73, 32'h0, 10'd0);
    set_vec(5, 32'h0000_5000, 16'd1, 1, 1, 0,
            32'h5000, 10'd1, 32'h0, 10'd0, 32'h0, 10'd0);

    tick();
    tick();
    i_rst = 1'b0;
    tick();
    chk("rst_desc_ready", 32'(desc_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(dma_read_valid), 0);
    chk("rst_done", 32'(desc_done), 0);
    chk("rst_issue_pulse", 32'(issue_pulse), 0);
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_addr", dma_read_addr, 0);
    chk("rst_len", 32'(dma_read_len), 0);
    chk("rst_issue_tag", 32'(issue_tag), 0);
    chk("rst_issue_len", 32'(issue_len), 0);

    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < vecs[v].nreq; r++) begin
        exp_addr_q.push_back(vecs[v].ea[r]);
        exp_len_q.push_back(vecs[v].el[r]);
      end
      start_desc(vecs[v].addr, vecs[v].len);
      issue_phase(vecs[v].nreq, vecs[v].hold, vecs[v].mode);
      finish_desc();
    end

    // zero-length descriptor
    start_desc(32'h0000_8000, 16'd0);
    chk("zero_no_valid", 32'(dma_read_valid), 0);
    tick();
    chk("zero_done", 32'(desc_done), 1);
    chk("zero_no_valid2", 32'(dma_read_valid), 0);
    tick();
    chk("zero_done_single", 32'(desc_done), 0);
    chk("zero_ready", 32'(desc_ready), 1);

    // credit throttle at four outstanding
    for (int r = 0; r < 8; r++) begin
      exp_addr_q.push_back(32'h0001_0000 + 32'(r) * 32'h200);
      exp_len_q.push_back(10'd128);
    end
    start_desc(32'h0001_0000, 16'd1024);
    issue_phase(4, 1, 0);
    repeat (5) begin
      chk("throttle_no_valid", 32'(dma_read_valid), 0);
      chk("throttle_busy", 32'(busy), 1);
      chk("throttle_outstanding", 32'(outstanding), 4);
      tick();
    end
    cpl_req_done = 1'b1;
    out_m--;
    tick();
    cpl_req_done = 1'b0;
    chk("throttle_credit_back", 32'(outstanding), 3);
    chk("throttle_not_yet", 32'(dma_read_valid), 0);
    tick();
    chk("throttle_release", 32'(dma_read_valid), 1);
    issue_phase(4, 1, 1);
    finish_desc();

    // stray completion while idle saturates at zero
    cpl_req_done = 1'b1;
    tick();
    cpl_req_done = 1'b0;
    chk("cpl_saturate", 32'(outstanding), 0);
    chk("cpl_idle_ready", 32'(desc_ready), 1);

    // reset while a request is offered with three outstanding
    for (int r = 0; r < 4; r++) begin
      exp_addr_q.push_back(32'h0002_0000 + 32'(r) * 32'h200);
      exp_len_q.push_back(10'd128);
    end
    start_desc(32'h0002_0000, 16'd512);
    issue_phase(3, 1, 0);
    cyc = 0;
    while (!dma_read_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    if (!dma_read_valid) fail_now("wait_fourth_request");
    chk("pre_reset_outstanding", 32'(outstanding), 3);
    i_rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(dma_read_valid), 0);
    chk("mid_rst_outstanding", 32'(outstanding), 0);
    chk("mid_rst_ready", 32'(desc_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_addr", dma_read_addr, 0);
    i_rst = 1'b0;
    out_m = 0;
    exp_addr_q.delete();
    exp_len_q.delete();
    tick();
    chk("post_rst_ready", 32'(desc_ready), 1);
    chk("post_rst_outstanding", 32'(outstanding), 0);

    exp_addr_q.push_back(32'h0000_3000);
    exp_len_q.push_back(10'd4);
    start_desc(32'h0000_3000, 16'd4);
    issue_phase(1, 1, 0);
    finish_desc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
